// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// ImemArbiter: shares a single-port, synchronous-read instruction memory
// between the IF fetch path and a program loader / debug port.
//
// One requester owns the memory each cycle. The fetch path normally has
// priority. The loader wins when fetch is not requesting, or once it has
// been denied STARVE_LIMIT cycles in a row. A loader grant while Load_Lock
// is set moves the arbiter into a locked burst. In that burst only the
// loader is served, until Load_Lock drops.
//
// Ports
//   Clk, Reset        rising-edge clock, asynchronous active-high reset
//   IF_Req/Addr/Kill  fetch request, byte address, flush of last fetch
//   IF_Stall          fetch denied this cycle (combinational)
//   IF_Valid          IF_Instruction carries last cycle's fetch data
//   IF_Instruction    fetched word, or BUBBLE when not valid
//   Load_Req/We/Lock  loader request, write enable, burst lock request
//   Load_Addr/Wdata   loader word address and write data
//   Load_Gnt          loader owns the memory this cycle (combinational)
//   Load_Rvalid/Rdata loader read data, one cycle after a granted read
//   IMEM_addr/we/wdata memory-side address, write enable, write data
//   IMEM_data         memory read data, one cycle after the address
// ---------------------------------------------------------------------------
module imem_arbiter #(
  parameter int          ADDR_WIDTH   = 10,
  parameter int          STARVE_LIMIT = 8,
  parameter logic [31:0] BUBBLE       = 32'h0000_0013
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  IF_Req,
  input  logic [31:0]           IF_Addr,
  input  logic                  IF_Kill,
  output logic                  IF_Stall,
  output logic                  IF_Valid,
  output logic [31:0]           IF_Instruction,
  input  logic                  Load_Req,
  input  logic                  Load_We,
  input  logic                  Load_Lock,
  input  logic [ADDR_WIDTH-1:0] Load_Addr,
  input  logic [31:0]           Load_Wdata,
  output logic                  Load_Gnt,
  output logic                  Load_Rvalid,
  output logic [31:0]           Load_Rdata,
  output logic [ADDR_WIDTH-1:0] IMEM_addr,
  output logic                  IMEM_we,
  output logic [31:0]           IMEM_wdata,
  input  logic [31:0]           IMEM_data
);

  typedef enum logic {ARB, LOCKED} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t                state;
  logic [7:0]            starve_cnt;
  logic                  fetch_grant;
  logic                  loader_grant;
  logic                  fetch_valid_q;
  logic                  load_rvalid_q;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  unused_addr_bits;

  // Byte offset bits and bits above the memory depth are dropped, so
  // fetch addresses wrap modulo the memory depth.
  assign fetch_addr       = IF_Addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{IF_Addr[31:ADDR_WIDTH+2], IF_Addr[1:0]};

  // Grant decision. In ARB, fetch has priority unless the loader has
  // starved for STARVE_LIMIT cycles. In LOCKED, the fetch path is shut
  // out completely, including the cycle in which Load_Lock drops.
  always_comb begin
    loader_grant = 1'b0;
    fetch_grant  = 1'b0;
    if (state == LOCKED) begin
      loader_grant = Load_Req;
    end else begin
      loader_grant = Load_Req & (!IF_Req | (starve_cnt == LIMIT));
      fetch_grant  = IF_Req & !loader_grant;
    end
  end

  // Memory-side mux. When nobody owns the memory, the address stays on
  // the last owner's value so the macro's address pins do not toggle.
  always_comb begin
    IMEM_addr = last_addr;
    IMEM_we   = 1'b0;
    if (loader_grant) begin
      IMEM_addr = Load_Addr;
      IMEM_we   = Load_We;
    end else if (fetch_grant) begin
      IMEM_addr = fetch_addr;
    end
  end

  assign IMEM_wdata = Load_Wdata;
  assign Load_Gnt   = loader_grant;
  assign IF_Stall   = IF_Req & !fetch_grant;

  // A kill in the response cycle squashes the fetched word at once,
  // without waiting for another edge.
  assign IF_Valid       = fetch_valid_q & !IF_Kill;
  assign IF_Instruction = IF_Valid ? IMEM_data : BUBBLE;
  assign Load_Rvalid    = load_rvalid_q;
  assign Load_Rdata     = IMEM_data;

  // Arbiter state, starvation counter, held address and response valids.
  // Reset drops all in-flight responses immediately. Any burst in progress
  // is abandoned. The starvation counter only runs in ARB. A loader that
  // is granted, or that stops asking, clears the counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= ARB;
      starve_cnt    <= '0;
      fetch_valid_q <= 1'b0;
      load_rvalid_q <= 1'b0;
      last_addr     <= '0;
    end else begin
      fetch_valid_q <= fetch_grant;
      load_rvalid_q <= loader_grant & !Load_We;
      if (loader_grant | fetch_grant) begin
        last_addr <= IMEM_addr;
      end
      case (state)
        ARB: begin
          if (Load_Req & !loader_grant) begin
            if (starve_cnt != LIMIT) begin
              starve_cnt <= starve_cnt + 8'd1;
            end
          end else begin
            starve_cnt <= '0;
          end
          if (loader_grant & Load_Lock) begin
            state <= LOCKED;
          end
        end
        LOCKED: begin
          starve_cnt <= '0;
          if (!Load_Lock) begin
            state <= ARB;
          end
        end
        default: begin
          state      <= ARB;
          starve_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single-port, synchronous-read instruction memory between the IF stage fetch path and a program loader/debug port. Each cycle it grants the memory to exactly one requester and generates a fetch stall when the loader wins. It returns read data with a registered valid, and enforces loader anti-starvation plus a locked burst mode for program download. It sits between the PC/IF logic and the IMEM macro.

Parameters:
ADDR_WIDTH, 10, IMEM word-address width (depth 2^ADDR_WIDTH words of 32 bits)
STARVE_LIMIT, 8, consecutive denied loader cycles after which the loader pre-empts fetch (1..255)
BUBBLE, 32'h0000_0013, instruction returned to IF when no valid fetch data (ADDI x0,x0,0)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
IF_Req  input  1  IF requests a fetch this cycle
IF_Addr  input  32  fetch byte address; word index = IF_Addr[ADDR_WIDTH+1:2]
IF_Kill  input  1  discard the fetch issued in the previous cycle (branch/jump flush)
IF_Stall  output  1  fetch not granted this cycle (combinational)
IF_Valid  output  1  IF_Instruction holds data fetched in the previous cycle (registered)
IF_Instruction  output  32  IMEM_data when IF_Valid, else BUBBLE
Load_Req  input  1  loader access request
Load_We  input  1  1 = write, 0 = read
Load_Lock  input  1  request exclusive burst ownership
Load_Addr  input  ADDR_WIDTH  loader word address
Load_Wdata  input  32  loader write data
Load_Gnt  output  1  loader owns memory this cycle (combinational)
Load_Rvalid  output  1  Load_Rdata valid, one cycle after a granted read (registered)
Load_Rdata  output  32  read data for loader
IMEM_addr  output  ADDR_WIDTH  memory word address
IMEM_we  output  1  memory write enable
IMEM_wdata  output  32  memory write data
IMEM_data  input  32  memory read data, valid one cycle after address

Behaviour:
- States: ARB, LOCKED. Reset -> ARB; starve_cnt=0; IF_Valid=0; Load_Rvalid=0 (IF_Instruction=BUBBLE). Reset is asynchronous and takes effect mid-burst or mid-read with no completion of any in-flight transaction.
- ARB grant: loader wins if Load_Req & (!IF_Req | starve_cnt==STARVE_LIMIT). Otherwise fetch wins if IF_Req. If neither requests, the memory is idle and IMEM_we=0.
- LOCKED grant: loader wins whenever Load_Req. Fetch is never granted, so IF_Stall=IF_Req.
- IF_Stall = IF_Req & !fetch_grant. Load_Gnt = loader_grant.
- Mux: fetch grant -> IMEM_addr=IF_Addr word index, IMEM_we=0. Loader grant -> IMEM_addr=Load_Addr, IMEM_we=Load_We, IMEM_wdata=Load_Wdata. Idle -> IMEM_addr holds the last value, IMEM_we=0.
- Writes complete at the granted edge. There is no response beyond Load_Gnt.
- IF_Valid <= fetch_grant & !IF_Kill_next. IF_Kill asserted in the cycle IF_Valid would be 1 forces IF_Instruction=BUBBLE and IF_Valid=0 combinationally in that cycle. Latency: grant at cycle N -> data at cycle N+1.
- Load_Rvalid <= loader_grant & !Load_We. Load_Rdata = IMEM_data (don't-care when !Load_Rvalid).
- starve_cnt: increments, saturating at STARVE_LIMIT, while Load_Req & !Load_Gnt. It clears when Load_Gnt=1 or Load_Req=0. It is only evaluated in ARB and held at 0 in LOCKED.
- ARB->LOCKED at an edge where Load_Gnt & Load_Lock. LOCKED->ARB at an edge where !Load_Lock. The cycle Load_Lock drops is still loader-owned; fetch resumes the next cycle.
- Simultaneous fetch and loader requests with starve_cnt<STARVE_LIMIT: fetch wins and the counter increments.
- Alias hazard: a loader write to the address being fetched in the same cycle cannot occur, because only one owner exists per cycle.
- IF_Addr bits [1:0] and bits above ADDR_WIDTH+1 are ignored; addresses wrap modulo depth.

Test Plan:
- Reset asserted mid-LOCKED burst -> immediately IF_Valid=0, Load_Rvalid=0, IF_Instruction=32'h13. After release, state is ARB and the first IF_Req is granted the same cycle.
- Fetch only: IF_Req=1, IF_Addr=0x0,0x4,0x8 with memory preloaded 0xA,0xB,0xC -> IF_Stall=0 throughout. IF_Instruction=0xA,0xB,0xC one cycle later each, with IF_Valid=1.
- Starvation: IF_Req=1 continuously, Load_Req=1 read at 0x5 (STARVE_LIMIT=8) -> Load_Gnt=0 for 8 cycles, Load_Gnt=1 with IF_Stall=1 on the 9th. Load_Rvalid=1 next cycle with memory[5], and the counter returns to 0.
- Locked burst: Load_Lock=1, writes 0x100..0x103 to words 0..3 while IF_Req=1 -> IF_Stall=1 for all 4 cycles plus the Lock-drop cycle. Subsequent fetches of 0x0..0xC return 0x100..0x103.
- Kill: fetch granted at 0x10, IF_Kill=1 next cycle -> IF_Valid=0 and IF_Instruction=32'h13 in that cycle. The following granted fetch returns normally.
- Idle loader: IF_Req=0, Load_Req=1 read -> granted immediately with starve_cnt=0. IMEM_we=0 when both requests are low.
